// File: rtl/cart_pkg.sv
// rtl/cart_pkg.sv - shared types, widths and byte-merge helper for the cartridge memory bridge.
package cart_pkg;

    localparam int CART_ROM_AW = 23;
    localparam int CART_MEM_AW = 25;

    typedef enum logic [2:0] {
        RESYNC,
        IDLE,
        RD_WAIT,
        WR_WAIT,
        DONE,
        PF_WAIT
    } state_t;

    typedef struct packed {
        logic                   valid;
        logic [CART_ROM_AW-1:0] tag;
        logic [15:0]            data;
    } cache_entry_t;

    function automatic logic [15:0] merge_bytes(input logic [15:0] old_w,
                                                input logic [15:0] new_w,
                                                input logic [1:0]  be);
        return {be[1] ? new_w[15:8] : old_w[15:8],
                be[0] ? new_w[7:0]  : old_w[7:0]};
    endfunction

endpackage

// File: rtl/cart_mem_bridge_if.sv
// rtl/cart_mem_bridge_if.sv - mapper-side ROM bus and SDRAM-side toggle-handshake bus.
interface cart_rom_if
    import cart_pkg::*;
#(
    parameter int AW = CART_ROM_AW
);
    logic [AW-1:0] ROM_A;
    logic [15:0]   ROM_DO;
    logic          ROM_RD;
    logic          ROM_WRL;
    logic          ROM_WRH;
    logic [15:0]   ROM_DI;
    logic          ROM_RDY;
    logic [AW-1:0] ROM_MASK;
    logic          WR_EN;
    logic          INVAL;

    modport master (
        output ROM_A, ROM_DO, ROM_RD, ROM_WRL, ROM_WRH, ROM_MASK, WR_EN, INVAL,
        input  ROM_DI, ROM_RDY
    );

    modport slave (
        input  ROM_A, ROM_DO, ROM_RD, ROM_WRL, ROM_WRH, ROM_MASK, WR_EN, INVAL,
        output ROM_DI, ROM_RDY
    );
endinterface

interface cart_mem_if
    import cart_pkg::*;
#(
    parameter int AW = CART_MEM_AW
);
    logic [AW-1:0] MEM_ADDR;
    logic [15:0]   MEM_DOUT;
    logic [15:0]   MEM_DIN;
    logic [1:0]    MEM_BE;
    logic          MEM_WE;
    logic          MEM_REQ;
    logic          MEM_ACK;

    modport master (
        output MEM_ADDR, MEM_DOUT, MEM_BE, MEM_WE, MEM_REQ,
        input  MEM_DIN, MEM_ACK
    );

    modport slave (
        input  MEM_ADDR, MEM_DOUT, MEM_BE, MEM_WE, MEM_REQ,
        output MEM_DIN, MEM_ACK
    );
endinterface

// File: rtl/cart_rd_cache.sv
// rtl/cart_rd_cache.sv - small read cache: hit compare, fill, byte-merge on write, invalidate.
module cart_rd_cache
    import cart_pkg::*;
#(
    parameter int ENTRIES = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   inval_i,
    input  logic [CART_ROM_AW-1:0] lookup_tag_i,
    output logic                   hit_o,
    output logic [15:0]            hit_data_o,
    input  logic                   fill_i,
    input  logic                   fill_idx_i,
    input  logic [CART_ROM_AW-1:0] fill_tag_i,
    input  logic [15:0]            fill_data_i,
    input  logic                   merge_i,
    input  logic [CART_ROM_AW-1:0] merge_tag_i,
    input  logic [15:0]            merge_data_i,
    input  logic [1:0]             merge_be_i
);

    cache_entry_t ent_q [ENTRIES];
    cache_entry_t ent_d [ENTRIES];

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            if (merge_i && ent_q[i].valid && ent_q[i].tag == merge_tag_i) begin
                ent_d[i].data = merge_bytes(ent_q[i].data, merge_data_i, merge_be_i);
            end
            if (fill_i && ((ENTRIES == 1) || (fill_idx_i == 1'(i)))) begin
                ent_d[i].valid = 1'b1;
                ent_d[i].tag   = fill_tag_i;
                ent_d[i].data  = fill_data_i;
            end
            // Invalidate beats a same-cycle fill so stale ROM contents never survive a download.
            if (inval_i) begin
                ent_d[i].valid = 1'b0;
            end
        end
    end

    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = 16'h0000;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].tag == lookup_tag_i) begin
                hit_o      = 1'b1;
                hit_data_o = ent_q[i].data;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: rtl/cart_mem_bridge.sv
// rtl/cart_mem_bridge.sv - mapper ROM bus to SDRAM toggle-handshake bridge with read cache.
// Optional CART_PREFETCH_EN adds a second entry filled by a next-word prefetch.
module cart_mem_bridge
    import cart_pkg::*;
#(
    parameter int                ROM_AW   = CART_ROM_AW,
    parameter int                MEM_AW   = CART_MEM_AW,
    parameter logic [MEM_AW-1:0] MEM_BASE = '0
) (
    input  logic       CLK,
    input  logic       RST,
    cart_rom_if.slave  rom,
    cart_mem_if.master mem
);

`ifdef CART_PREFETCH_EN
    localparam int ENTRIES = 2;
`else
    localparam int ENTRIES = 1;
`endif

    state_t              state_q, state_d;
    logic                act_q;
    logic [15:0]         rom_di_q, rom_di_d;
    logic                rom_rdy_q, rom_rdy_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]         mem_dout_q, mem_dout_d;
    logic [1:0]          mem_be_q, mem_be_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_req_q, mem_req_d;
    logic [ROM_AW-1:0]   lat_addr_q, lat_addr_d;
    logic [15:0]         lat_data_q, lat_data_d;
    logic [1:0]          lat_be_q, lat_be_d;
    logic                pend_q, pend_d;
    logic                inval_seen_q, inval_seen_d;
`ifdef CART_PREFETCH_EN
    logic                pf_armed_q, pf_armed_d;
    logic [ROM_AW-1:0]   pf_addr_q, pf_addr_d;
`endif

    logic                act, start_live, ack_match;
    logic [ROM_AW-1:0]   live_addr, cur_addr;
    logic [15:0]         cur_data;
    logic [1:0]          cur_be;
    logic                cur_start, cur_wr;
    logic                c_hit, fill_en, fill_idx, merge_en;
    logic [15:0]         c_data;
    logic [ROM_AW-1:0]   fill_tag;

    function automatic logic [MEM_AW-1:0] byte_addr(input logic [ROM_AW-1:0] w);
        return MEM_BASE + MEM_AW'({w, 1'b0});
    endfunction

    assign act        = rom.ROM_RD | rom.ROM_WRL | rom.ROM_WRH;
    assign start_live = act & ~act_q;
    assign ack_match  = (mem.MEM_ACK == mem_req_q);
    assign live_addr  = rom.ROM_A & rom.ROM_MASK;

    // An access parked during a prefetch is replayed from the latch instead of the live bus.
    assign cur_start = pend_q | start_live;
    assign cur_addr  = pend_q ? lat_addr_q : live_addr;
    assign cur_data  = pend_q ? lat_data_q : rom.ROM_DO;
    assign cur_be    = pend_q ? lat_be_q : {rom.ROM_WRH, rom.ROM_WRL};
    assign cur_wr    = |cur_be;

    cart_rd_cache #(.ENTRIES(ENTRIES)) u_cache (
        .CLK          (CLK),
        .RST          (RST),
        .inval_i      (rom.INVAL),
        .lookup_tag_i (cur_addr),
        .hit_o        (c_hit),
        .hit_data_o   (c_data),
        .fill_i       (fill_en),
        .fill_idx_i   (fill_idx),
        .fill_tag_i   (fill_tag),
        .fill_data_i  (mem.MEM_DIN),
        .merge_i      (merge_en),
        .merge_tag_i  (lat_addr_q),
        .merge_data_i (lat_data_q),
        .merge_be_i   (lat_be_q)
    );

    always_comb begin
        state_d      = state_q;
        rom_di_d     = rom_di_q;
        rom_rdy_d    = rom_rdy_q;
        mem_addr_d   = mem_addr_q;
        mem_dout_d   = mem_dout_q;
        mem_be_d     = mem_be_q;
        mem_we_d     = mem_we_q;
        mem_req_d    = mem_req_q;
        lat_addr_d   = lat_addr_q;
        lat_data_d   = lat_data_q;
        lat_be_d     = lat_be_q;
        pend_d       = pend_q;
        inval_seen_d = inval_seen_q | rom.INVAL;
        fill_en      = 1'b0;
        fill_idx     = 1'b0;
        fill_tag     = lat_addr_q;
        merge_en     = 1'b0;
`ifdef CART_PREFETCH_EN
        pf_armed_d   = pf_armed_q;
        pf_addr_d    = pf_addr_q;
`endif

        case (state_q)
            RESYNC: begin
                mem_req_d = mem.MEM_ACK;
                state_d   = IDLE;
            end

            IDLE: begin
                if (cur_start) begin
                    lat_addr_d = cur_addr;
                    lat_data_d = cur_data;
                    lat_be_d   = cur_be;
                    pend_d     = 1'b0;
`ifdef CART_PREFETCH_EN
                    pf_armed_d = 1'b0;
`endif
                    if (cur_wr) begin
                        if (rom.WR_EN) begin
                            mem_addr_d   = byte_addr(cur_addr);
                            mem_dout_d   = cur_data;
                            mem_be_d     = cur_be;
                            mem_we_d     = 1'b1;
                            mem_req_d    = ~mem_req_q;
                            inval_seen_d = rom.INVAL;
                            state_d      = WR_WAIT;
                        end else begin
                            rom_rdy_d = 1'b1;
                            state_d   = DONE;
                        end
                    end else if (c_hit) begin
                        rom_di_d  = c_data;
                        rom_rdy_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        mem_addr_d   = byte_addr(cur_addr);
                        mem_be_d     = 2'b11;
                        mem_we_d     = 1'b0;
                        mem_req_d    = ~mem_req_q;
                        inval_seen_d = rom.INVAL;
                        state_d      = RD_WAIT;
                    end
                end
`ifdef CART_PREFETCH_EN
                else if (pf_armed_q) begin
                    mem_addr_d   = byte_addr(pf_addr_q);
                    mem_be_d     = 2'b11;
                    mem_we_d     = 1'b0;
                    mem_req_d    = ~mem_req_q;
                    inval_seen_d = rom.INVAL;
                    pf_armed_d   = 1'b0;
                    state_d      = PF_WAIT;
                end
`endif
            end

            RD_WAIT: begin
                if (ack_match) begin
                    rom_di_d  = mem.MEM_DIN;
                    rom_rdy_d = 1'b1;
                    fill_en   = ~inval_seen_q;
                    state_d   = DONE;
`ifdef CART_PREFETCH_EN
                    pf_armed_d = 1'b1;
                    pf_addr_d  = (lat_addr_q + ROM_AW'(1)) & rom.ROM_MASK;
`endif
                end
            end

            WR_WAIT: begin
                if (ack_match) begin
                    merge_en  = 1'b1;
                    rom_rdy_d = 1'b1;
                    state_d   = DONE;
                end
            end

            DONE: begin
                if (!act) begin
                    rom_rdy_d = 1'b0;
                    state_d   = IDLE;
                end
            end

`ifdef CART_PREFETCH_EN
            PF_WAIT: begin
                if (start_live && !pend_q) begin
                    lat_addr_d = live_addr;
                    lat_data_d = rom.ROM_DO;
                    lat_be_d   = {rom.ROM_WRH, rom.ROM_WRL};
                    pend_d     = 1'b1;
                end
                if (ack_match) begin
                    fill_en  = ~inval_seen_q;
                    fill_idx = 1'b1;
                    fill_tag = pf_addr_q;
                    state_d  = IDLE;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= RESYNC;
            act_q        <= 1'b0;
            rom_di_q     <= 16'h0000;
            rom_rdy_q    <= 1'b0;
            mem_addr_q   <= MEM_BASE;
            mem_dout_q   <= 16'h0000;
            mem_be_q     <= 2'b00;
            mem_we_q     <= 1'b0;
            mem_req_q    <= 1'b0;
            lat_addr_q   <= '0;
            lat_data_q   <= 16'h0000;
            lat_be_q     <= 2'b00;
            pend_q       <= 1'b0;
            inval_seen_q <= 1'b0;
`ifdef CART_PREFETCH_EN
            pf_armed_q   <= 1'b0;
            pf_addr_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            act_q        <= act;
            rom_di_q     <= rom_di_d;
            rom_rdy_q    <= rom_rdy_d;
            mem_addr_q   <= mem_addr_d;
            mem_dout_q   <= mem_dout_d;
            mem_be_q     <= mem_be_d;
            mem_we_q     <= mem_we_d;
            mem_req_q    <= mem_req_d;
            lat_addr_q   <= lat_addr_d;
            lat_data_q   <= lat_data_d;
            lat_be_q     <= lat_be_d;
            pend_q       <= pend_d;
            inval_seen_q <= inval_seen_d;
`ifdef CART_PREFETCH_EN
            pf_armed_q   <= pf_armed_d;
            pf_addr_q    <= pf_addr_d;
`endif
        end
    end

    assign rom.ROM_DI   = rom_di_q;
    assign rom.ROM_RDY  = rom_rdy_q;
    assign mem.MEM_ADDR = mem_addr_q;
    assign mem.MEM_DOUT = mem_dout_q;
    assign mem.MEM_BE   = mem_be_q;
    assign mem.MEM_WE   = mem_we_q;
    assign mem.MEM_REQ  = mem_req_q;

endmodule

// File: tb/tb_cart_mem_bridge.sv
// tb/tb_cart_mem_bridge.sv - self-checking bench for cart_mem_bridge.
module tb_cart_mem_bridge;

    logic CLK;
    logic RST;

    cart_rom_if rom ();
    cart_mem_if mem ();

    cart_mem_bridge dut (
        .CLK (CLK),
        .RST (RST),
        .rom (rom),
        .mem (mem)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] defval(input logic [22:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    // SDRAM controller model: fixed latency, acknowledges by copying MEM_REQ.
    logic [15:0] ctrl_mem [logic [22:0]];
    int          mem_lat = 5;
    int          cnt = 0;
    int          req_count = 0;
    int          stab_errs = 0;
    logic [24:0] snap_addr, last_addr;
    logic [15:0] snap_dout;
    logic [1:0]  snap_be, last_be;
    logic        snap_we, last_we;

    always @(posedge CLK) begin
        if (RST) begin
            mem.MEM_ACK <= 1'b1;
            mem.MEM_DIN <= 16'h0000;
            cnt <= 0;
        end else if (mem.MEM_REQ != mem.MEM_ACK) begin
            if (cnt == 0) begin
                snap_addr <= mem.MEM_ADDR;
                snap_dout <= mem.MEM_DOUT;
                snap_be   <= mem.MEM_BE;
                snap_we   <= mem.MEM_WE;
            end else if (snap_addr != mem.MEM_ADDR || snap_be != mem.MEM_BE ||
                         snap_we != mem.MEM_WE || (mem.MEM_WE && snap_dout != mem.MEM_DOUT)) begin
                stab_errs <= stab_errs + 1;
            end
            if (cnt >= mem_lat) begin
                logic [22:0] k;
                logic [15:0] old;
                k   = 23'(mem.MEM_ADDR >> 1);
                old = ctrl_mem.exists(k) ? ctrl_mem[k] : defval(k);
                if (mem.MEM_WE) begin
                    ctrl_mem[k] = {mem.MEM_BE[1] ? mem.MEM_DOUT[15:8] : old[15:8],
                                   mem.MEM_BE[0] ? mem.MEM_DOUT[7:0]  : old[7:0]};
                end else begin
                    mem.MEM_DIN <= old;
                end
                mem.MEM_ACK <= mem.MEM_REQ;
                last_addr   <= mem.MEM_ADDR;
                last_be     <= mem.MEM_BE;
                last_we     <= mem.MEM_WE;
                req_count   <= req_count + 1;
                cnt <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    task automatic access(input logic [22:0] a, input logic rd, input logic wrl, input logic wrh,
                          input logic [15:0] d, output logic [15:0] di, output int lat);
        @(negedge CLK);
        rom.ROM_A   = a;
        rom.ROM_DO  = d;
        rom.ROM_RD  = rd;
        rom.ROM_WRL = wrl;
        rom.ROM_WRH = wrh;
        lat = 0;
        di  = 16'h0000;
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK);
            if (rom.ROM_RDY) begin
                lat = i;
                di  = rom.ROM_DI;
                break;
            end
        end
        chk("rdy_seen", 32'(lat != 0), 32'd1);
        chk("rdy_held", 32'(rom.ROM_RDY), 32'd1);
        rom.ROM_RD  = 1'b0;
        rom.ROM_WRL = 1'b0;
        rom.ROM_WRH = 1'b0;
        @(negedge CLK);
        chk("rdy_drop", 32'(rom.ROM_RDY), 32'd0);
        @(negedge CLK);
    endtask

    task automatic pulse_inval();
        @(negedge CLK);
        rom.INVAL = 1'b1;
        @(negedge CLK);
        rom.INVAL = 1'b0;
    endtask

    typedef struct {
        logic [22:0] a;
        logic        rd, wrl, wrh;
        logic [15:0] d;
        logic        wr_en, inval;
        logic [15:0] exp_di;
        int          exp_reqs;
        logic [24:0] exp_addr;
        logic [1:0]  exp_be;
        logic        exp_we;
    } vec_t;

    vec_t vecs [11];

    // Reference model state for the random phase: one cache entry plus a private memory image.
    logic        m_valid;
    logic [22:0] m_tag;
    logic [15:0] m_data;
    logic [15:0] ref_mem [logic [22:0]];

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] di;
        int          lat, r0, pulses;
        logic [22:0] a, mask, msk;
        logic [15:0] d, expd, cur;
        logic [1:0]  be;
        logic        we_en, hit;

        RST          = 1'b1;
        rom.ROM_A    = '0;
        rom.ROM_DO   = '0;
        rom.ROM_RD   = 1'b0;
        rom.ROM_WRL  = 1'b0;
        rom.ROM_WRH  = 1'b0;
        rom.ROM_MASK = 23'h1FFFFF;
        rom.WR_EN    = 1'b1;
        rom.INVAL    = 1'b0;
        ctrl_mem[23'h000100] = 16'hBEEF;

        repeat (3) @(negedge CLK);
        chk("rst_rom_di",   32'(rom.ROM_DI),   32'h0);
        chk("rst_rom_rdy",  32'(rom.ROM_RDY),  32'h0);
        chk("rst_mem_req",  32'(mem.MEM_REQ),  32'h0);
        chk("rst_mem_we",   32'(mem.MEM_WE),   32'h0);
        chk("rst_mem_be",   32'(mem.MEM_BE),   32'h0);
        chk("rst_mem_addr", 32'(mem.MEM_ADDR), 32'h0);
        chk("rst_mem_dout", 32'(mem.MEM_DOUT), 32'h0);
        RST = 1'b0;
        @(negedge CLK);
        chk("resync_req", 32'(mem.MEM_REQ), 32'h1);
        repeat (5) @(negedge CLK);
        chk("no_phantom_req", 32'(req_count), 32'h0);
        chk("idle_req_eq_ack", 32'(mem.MEM_REQ == mem.MEM_ACK), 32'h1);

`ifndef CART_PREFETCH_EN
        //               a            rd   wrl  wrh  d         wren inv  exp_di    reqs addr        be     we
        vecs[0]  = '{23'h000100, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1, 25'h000200, 2'b11, 1'b0};
        vecs[1]  = '{23'h000100, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 0, 25'h0,      2'b00, 1'b0};
        vecs[2]  = '{23'h000100, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0000, 1, 25'h000200, 2'b01, 1'b1};
        vecs[3]  = '{23'h000100, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hBE34, 0, 25'h0,      2'b00, 1'b0};
        vecs[4]  = '{23'h200100, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hBE34, 0, 25'h0,      2'b00, 1'b0};
        vecs[5]  = '{23'h200100, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hBE34, 1, 25'h000200, 2'b11, 1'b0};
        vecs[6]  = '{23'h000100, 1'b0, 1'b0, 1'b1, 16'hAB00, 1'b0, 1'b0, 16'h0000, 0, 25'h0,      2'b00, 1'b0};
        vecs[7]  = '{23'h000100, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hBE34, 0, 25'h0,      2'b00, 1'b0};
        vecs[8]  = '{23'h000100, 1'b1, 1'b0, 1'b1, 16'h5600, 1'b1, 1'b0, 16'h0000, 1, 25'h000200, 2'b10, 1'b1};
        vecs[9]  = '{23'h000100, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h5634, 0, 25'h0,      2'b00, 1'b0};
        vecs[10] = '{23'h000300, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hA6A5, 1, 25'h000600, 2'b11, 1'b0};

        for (int v = 0; v < 11; v++) begin
            if (vecs[v].inval) pulse_inval();
            rom.WR_EN = vecs[v].wr_en;
            r0 = req_count;
            access(vecs[v].a, vecs[v].rd, vecs[v].wrl, vecs[v].wrh, vecs[v].d, di, lat);
            chk($sformatf("vec%0d_reqs", v), 32'(req_count - r0), 32'(vecs[v].exp_reqs));
            if (vecs[v].rd && !(vecs[v].wrl || vecs[v].wrh)) begin
                chk($sformatf("vec%0d_data", v), 32'(di), 32'(vecs[v].exp_di));
                if (vecs[v].exp_reqs == 0) chk($sformatf("vec%0d_hit_lat", v), 32'(lat), 32'd1);
            end
            if (vecs[v].exp_reqs == 1) begin
                chk($sformatf("vec%0d_addr", v), 32'(last_addr), 32'(vecs[v].exp_addr));
                chk($sformatf("vec%0d_be", v),   32'(last_be),   32'(vecs[v].exp_be));
                chk($sformatf("vec%0d_we", v),   32'(last_we),   32'(vecs[v].exp_we));
            end
        end
        rom.WR_EN = 1'b1;

        // Strobe dropped mid-read: memory cycle completes, ROM_RDY pulses exactly once.
        mem_lat = 6;
        r0 = req_count;
        pulses = 0;
        expd = 16'h0000;
        @(negedge CLK);
        rom.ROM_A  = 23'h000500;
        rom.ROM_RD = 1'b1;
        repeat (2) @(negedge CLK);
        rom.ROM_RD = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (rom.ROM_RDY) begin
                pulses++;
                expd = rom.ROM_DI;
            end
        end
        chk("drop_rdy_pulses", 32'(pulses), 32'd1);
        chk("drop_reqs", 32'(req_count - r0), 32'd1);
        chk("drop_data", 32'(expd), 32'(defval(23'h000500)));

        // INVAL during RD_WAIT: data delivered, but not cached.
        r0 = req_count;
        fork
            access(23'h000600, 1'b1, 1'b0, 1'b0, 16'h0, di, lat);
            begin
                repeat (3) @(negedge CLK);
                rom.INVAL = 1'b1;
                @(negedge CLK);
                rom.INVAL = 1'b0;
            end
        join
        chk("inval_rd_data", 32'(di), 32'(defval(23'h000600)));
        access(23'h000600, 1'b1, 1'b0, 1'b0, 16'h0, di, lat);
        chk("inval_rd_refetch", 32'(req_count - r0), 32'd2);
        chk("inval_rd_data2", 32'(di), 32'(defval(23'h000600)));

        // Random traffic against the behavioural model.
        pulse_inval();
        m_valid = 1'b0;
        for (int n = 0; n < 250; n++) begin
            mem_lat = $urandom_range(1, 4);
            case ($urandom_range(0, 2))
                0:       mask = 23'h7FFFFF;
                1:       mask = 23'h1FFFFF;
                default: mask = 23'h0000FF;
            endcase
            rom.ROM_MASK = mask;
            if ($urandom_range(0, 9) == 0) begin
                pulse_inval();
                m_valid = 1'b0;
            end
            a   = 23'($urandom_range(0, 3)) << 20 | 23'($urandom_range(16, 23));
            msk = a & mask;
            cur = ref_mem.exists(msk) ? ref_mem[msk] : defval(msk);
            hit = m_valid && (m_tag == msk);
            r0  = req_count;
            if ($urandom_range(0, 9) < 6) begin
                access(a, 1'b1, 1'b0, 1'b0, 16'h0, di, lat);
                expd = hit ? m_data : cur;
                chk("rnd_rd_data", 32'(di), 32'(expd));
                chk("rnd_rd_reqs", 32'(req_count - r0), hit ? 32'd0 : 32'd1);
                if (hit) chk("rnd_hit_lat", 32'(lat), 32'd1);
                m_valid = 1'b1;
                m_tag   = msk;
                m_data  = expd;
            end else begin
                be    = 2'($urandom_range(1, 3));
                d     = 16'($urandom);
                we_en = 1'($urandom_range(0, 1));
                rom.WR_EN = we_en;
                access(a, 1'b0, be[0], be[1], d, di, lat);
                chk("rnd_wr_reqs", 32'(req_count - r0), we_en ? 32'd1 : 32'd0);
                if (we_en) begin
                    ref_mem[msk] = {be[1] ? d[15:8] : cur[15:8], be[0] ? d[7:0] : cur[7:0]};
                    if (hit) m_data = {be[1] ? d[15:8] : m_data[15:8], be[0] ? d[7:0] : m_data[7:0]};
                end
                rom.WR_EN = 1'b1;
            end
        end
`else
        // Prefetch: a miss at 0x10 prefetches 0x11; a read of 0x11 during the prefetch is a hit.
        mem_lat = 5;
        r0 = req_count;
        access(23'h000010, 1'b1, 1'b0, 1'b0, 16'h0, di, lat);
        chk("pf_miss_data", 32'(di), 32'(defval(23'h000010)));
        access(23'h000011, 1'b1, 1'b0, 1'b0, 16'h0, di, lat);
        chk("pf_hit_data", 32'(di), 32'(defval(23'h000011)));
        chk("pf_reqs", 32'(req_count - r0), 32'd2);
        chk("pf_addr", 32'(last_addr), 32'h22);
`endif

        repeat (4) @(negedge CLK);
        chk("mem_stable", 32'(stab_errs), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cart_mem_bridge.md
Name: cart_mem_bridge

Overview:
- Sits directly downstream of the cartridge mapper.
- Consumes the mapper's translated ROM-space bus (ROM_A/ROM_RD/ROM_WRL/ROM_WRH/ROM_DO) and returns ROM_DI plus a ready strobe used for DTACK generation.
- Converts each access into a single-word toggle-handshake request to the SDRAM controller.
- Holds a one-entry read cache so repeated fetches of the same word cost no memory cycle.

Parameters:
- ROM_AW, 23, word-address width of ROM_A (address bits [23:1]).
- MEM_AW, 25, byte-address width of MEM_ADDR.
- MEM_BASE, 25'h0, byte offset of the cartridge region in SDRAM.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- ROM_A  in  23  word address from mapper.
- ROM_DO  in  16  write data from mapper.
- ROM_RD  in  1  read strobe (level, held for the whole access).
- ROM_WRL  in  1  low-byte write strobe (level).
- ROM_WRH  in  1  high-byte write strobe (level).
- ROM_DI  out  16  read data to mapper.
- ROM_RDY  out  1  current access complete; held until all strobes drop.
- ROM_MASK  in  23  word-address mask (ROM size - 1); applied before memory issue.
- WR_EN  in  1  permit writes into ROM space; when 0, writes ack without a memory cycle.
- INVAL  in  1  invalidate the cache (ROM download / mapper bank change).
- MEM_ADDR  out  25  byte address = MEM_BASE + {ROM_A & ROM_MASK, 1'b0}.
- MEM_DOUT  out  16  write data.
- MEM_DIN  in  16  read data, valid when MEM_ACK == MEM_REQ.
- MEM_BE  out  2  byte enables {H,L}.
- MEM_WE  out  1  1 = write cycle.
- MEM_REQ  out  1  request toggle.
- MEM_ACK  in  1  acknowledge toggle; controller copies MEM_REQ when done.

Behaviour:
- Reset values:
  - ROM_DI=0, ROM_RDY=0, MEM_REQ=0, MEM_WE=0, MEM_BE=0, MEM_ADDR=MEM_BASE, MEM_DOUT=0.
  - Cache valid=0; state=RESYNC.
- Access start: rising edge of act = ROM_RD|ROM_WRL|ROM_WRH, sampled in IDLE. Address, data and strobes are latched on that cycle.
- FSM:
  - RESYNC: MEM_REQ<=MEM_ACK; -> IDLE next cycle. Avoids a phantom request after a mid-transaction reset.
  - IDLE:
    - Read hit (valid && tag==masked addr): ROM_DI<=cache data, ROM_RDY<=1 next cycle, -> DONE. Latency 1.
    - Read miss: drive MEM_*, toggle MEM_REQ, -> RD_WAIT.
    - Write with WR_EN=1: MEM_WE=1, MEM_BE={WRH,WRL}, toggle MEM_REQ, -> WR_WAIT.
    - Write with WR_EN=0: ROM_RDY<=1, -> DONE.
  - RD_WAIT: when MEM_ACK==MEM_REQ, ROM_DI<=MEM_DIN, fill cache (tag, data, valid=1), ROM_RDY<=1, -> DONE.
  - WR_WAIT: when ACK==REQ, ROM_RDY<=1, -> DONE. If the tag matches, merge the written bytes into the cache entry.
  - DONE: hold ROM_RDY and ROM_DI until act==0, then ROM_RDY<=0, -> IDLE.
- Strobes that drop before completion: the memory cycle still finishes. ROM_RDY pulses at most 1 cycle, then the FSM returns to IDLE. No abort.
- Address change while act stays high: not a new access. The mapper must deassert strobes between accesses.
- Read and write strobes both high at the start: write wins.
- INVAL:
  - Clears valid in every state; takes priority over a same-cycle fill.
  - If asserted during RD_WAIT, the returned data is still delivered to ROM_DI but is not cached.
- Address arithmetic: the mask is applied before the tag compare. Wrap-around at ROM size is implicit; addresses beyond the mask alias.
- MEM_* outputs are stable from the request toggle until the acknowledge.

Optional Feature:
- CART_PREFETCH_EN defined:
  - Adds a second cache entry.
  - After a read miss completes and the FSM is in DONE/IDLE with no pending access, issue a read of (addr+1)&ROM_MASK into entry 1 (state PF_WAIT).
  - A new access arriving during PF_WAIT is latched and serviced after the prefetch acknowledge.
  - Hits on either entry. Writes merge into whichever entry matches. INVAL clears both.
- Undefined: single entry, no PF_WAIT state, no speculative memory traffic.

Decomposition:
- Package cart_pkg:
  - State enum (RESYNC, IDLE, RD_WAIT, WR_WAIT, DONE, PF_WAIT).
  - ROM_AW / MEM_AW constants.
  - Cache-entry struct {valid, tag[22:0], data[15:0]}.
- Sub-module cart_rd_cache: entry storage, hit compare, byte-merge on write, fill, invalidate.

Test Plan:
- Reset with MEM_ACK=1, then release -> MEM_REQ becomes 1 within 1 cycle; no MEM request issued until the first strobe.
- Read 0x000100, MASK=0x1FFFFF, memory returns 0xBEEF after 5 cycles -> one REQ toggle, MEM_ADDR=0x000200, ROM_DI=0xBEEF, ROM_RDY high until RD drops.
- Repeat the same read -> no REQ toggle, ROM_RDY 1 cycle after strobe, ROM_DI=0xBEEF.
- ROM_WRL only to 0x000100, data 0x1234, WR_EN=1 -> MEM_BE=2'b01, MEM_WE=1. Subsequent read hits, returns 0xBE34.
- Read 0x200100 with MASK=0x1FFFFF -> hits the entry for 0x000100; INVAL then the same read -> miss and memory cycle.
- CART_PREFETCH_EN: miss at 0x000010 -> second request at MEM_ADDR 0x000022. A read of 0x000011 issued mid-prefetch completes after the ACK with no third request.
